node_mac_serial: RTL and testbench

- Time-multiplexed successor to the fully parallel per-neuron nodes in the generated layer files.
- Each instance computes one neuron per frame: y = ReLU/saturate(round((BIAS + sum over i of A[i]*W[i]) >> FRAC_SH)).
- It uses one signed multiplier and streams NUM_IN activations through a valid/ready handshake.
- Weights and bias are runtime-writable registers, not fixed parameters, so one RTL serves every node in a layer.

---
 rtl/node_mac_serial.sv | 168 ++++++++++++++++
 tb/tb_node_mac_serial.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_mac_serial.sv
// rtl/node_mac_serial.sv - time-multiplexed single-multiplier neuron node
//
// Purpose:
//   Computes one neuron per frame from NUM_IN streamed activations:
//     y = clamp(round((bias + sum A[i]*W[i]) >> FRAC_SH), 0, OUT_MAX)
//   Weights and bias live in runtime-writable registers so a single instance
//   can be retargeted to any node of a layer.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_data    activation stream (signed DW bits)
//   in_ready            high only while collecting a frame
//   w_we/w_addr/w_data  weight register write port
//   b_we/b_data         bias register write port
//   out_valid/out_data  registered result, held until out_ready
//   out_ready           consumer accepts the result
module node_mac_serial #(
  parameter int NUM_IN   = 30,
  parameter int DW       = 8,
  parameter int ACC_W    = 23,
  parameter int FRAC_SH  = 6,
  parameter int BIAS_RST = -512,
  parameter int OUT_MAX  = 127,
  localparam int AW      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [DW-1:0]    in_data,
  output logic                    in_ready,
  input  logic                    w_we,
  input  logic [AW-1:0]           w_addr,
  input  logic signed [DW-1:0]    w_data,
  input  logic                    b_we,
  input  logic signed [ACC_W-1:0] b_data,
  output logic                    out_valid,
  output logic [DW-1:0]           out_data,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FIN,
    S_HOLD
  } state_t;

  localparam logic signed [ACC_W-1:0] BIAS_RST_C = ACC_W'(BIAS_RST);
  localparam logic [AW-1:0]           CNT_LAST   = AW'(NUM_IN - 1);
  localparam logic [ACC_W:0]          OUT_MAX_W  = (ACC_W + 1)'(OUT_MAX);
  localparam logic [DW-1:0]           OUT_MAX_C  = DW'(OUT_MAX);

  state_t                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] bias_q, bias_d;
  logic                    out_valid_q, out_valid_d;
  logic [DW-1:0]           out_data_q, out_data_d;
  logic signed [DW-1:0]    w_q [NUM_IN];
  logic signed [DW-1:0]    w_d [NUM_IN];

  logic                    accept;
  logic signed [DW-1:0]    w_rd;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_sh;
  logic [ACC_W:0]          rnd;
  logic [DW-1:0]           result;

  assign in_ready  = (state_q == S_RUN);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Datapath: one signed multiply per accepted activation.
  always_comb begin
    accept   = in_valid && in_ready;
    w_rd     = w_q[cnt_q];
    prod     = in_data * w_rd;
    prod_ext = ACC_W'(prod);
    // The bias is folded in on the first beat, so no separate clear cycle.
    acc_base = (cnt_q == '0) ? bias_q : acc_q;
  end

  // Output conversion: negative clamps to zero, otherwise round half up
  // using the bit just below the cut, then saturate. The extra MSB of rnd
  // keeps the rounding increment from wrapping.
  always_comb begin
    acc_sh = acc_q >>> FRAC_SH;
    rnd    = {1'b0, acc_sh} + (ACC_W + 1)'(acc_q[FRAC_SH-1]);
    if (acc_q[ACC_W-1]) begin
      result = '0;
    end else if (rnd > OUT_MAX_W) begin
      result = OUT_MAX_C;
    end else begin
      result = rnd[DW-1:0];
    end
  end

  // Register file writes. Addresses at or above NUM_IN match no entry and
  // are dropped; a same-cycle accept reads w_q, i.e. the old weight.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      w_d[i] = (w_we && (w_addr == AW'(i))) ? w_data : w_q[i];
    end
    bias_d = b_we ? b_data : bias_q;
  end

  // Frame sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_RUN: begin
        if (accept) begin
          acc_d = acc_base + prod_ext;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      S_FIN: begin
        out_data_d  = result;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      acc_q       <= '0;
      bias_q      <= BIAS_RST_C;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < NUM_IN; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

endmodule

// File: tb/tb_node_mac_serial.sv
// tb/tb_node_mac_serial.sv - self-checking bench for node_mac_serial
module tb_node_mac_serial;

  localparam int NUM_IN   = 4;
  localparam int DW       = 8;
  localparam int ACC_W    = 23;
  localparam int FRAC_SH  = 6;
  localparam int BIAS_RST = -512;
  localparam int OUT_MAX  = 127;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    in_valid = 1'b0;
  logic signed [DW-1:0]    in_data = '0;
  logic                    in_ready;
  logic                    w_we = 1'b0;
  logic [1:0]              w_addr = '0;
  logic signed [DW-1:0]    w_data = '0;
  logic                    b_we = 1'b0;
  logic signed [ACC_W-1:0] b_data = '0;
  logic                    out_valid;
  logic [DW-1:0]           out_data;
  logic                    out_ready = 1'b0;

  node_mac_serial #(
    .NUM_IN  (NUM_IN),
    .DW      (DW),
    .ACC_W   (ACC_W),
    .FRAC_SH (FRAC_SH),
    .BIAS_RST(BIAS_RST),
    .OUT_MAX (OUT_MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .b_we     (b_we),
    .b_data   (b_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of a frame plus the handshake
  // timing rules (result appears two cycles after the last beat, producer
  // blocked until the result is taken).
  int mw [NUM_IN];
  int mb   = BIAS_RST;
  int macc = 0;
  int mn   = 0;
  bit mbusy = 1'b0;
  bit mwait = 1'b0;
  bit mov   = 1'b0;
  int mod   = 0;

  function automatic int out_rule(input int acc_in);
    int a;
    int r;
    a = (acc_in <<< (32 - ACC_W)) >>> (32 - ACC_W);
    if (a < 0) return 0;
    r = (a + (1 << (FRAC_SH - 1))) / (1 << FRAC_SH);
    return (r > OUT_MAX) ? OUT_MAX : r;
  endfunction

  always @(posedge clk) begin
    bit hs;
    bit fin;
    bit acc_ev;
    int p;
    if (reset) begin
      mbusy = 1'b0;
      mwait = 1'b0;
      mov   = 1'b0;
      mod   = 0;
      mn    = 0;
      macc  = 0;
      mb    = BIAS_RST;
      for (int i = 0; i < NUM_IN; i++) mw[i] = 0;
    end else begin
      hs     = mov && out_ready;
      fin    = mwait;
      acc_ev = in_valid && !mbusy;
      if (hs) begin
        mov   = 1'b0;
        mbusy = 1'b0;
      end
      if (fin) begin
        mod   = out_rule(macc);
        mov   = 1'b1;
        mwait = 1'b0;
      end
      if (acc_ev) begin
        p    = int'(in_data) * mw[mn];
        macc = (mn == 0) ? (mb + p) : (macc + p);
        mn++;
        if (mn == NUM_IN) begin
          mn    = 0;
          mbusy = 1'b1;
          mwait = 1'b1;
        end
      end
      if (w_we) mw[w_addr] = int'(w_data);
      if (b_we) mb = int'(b_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, 32'(!mbusy));
      check("out_valid", out_valid, 32'(mov));
      check("out_data", out_data, 32'(mod));
    end
  end

  // All directed tasks start and end just after a falling edge.
  task automatic wr_w(input int a, input int d);
    w_we = 1'b1;
    w_addr = a[1:0];
    w_data = d[7:0];
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic wr_b(input int d);
    b_we = 1'b1;
    b_data = d[ACC_W-1:0];
    @(negedge clk);
    b_we = 1'b0;
  endtask

  task automatic send_frame(input int a0, input int a1, input int a2, input int a3,
                            input bit col, input int col_w, output int stalls);
    int a [NUM_IN];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    stalls = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_valid = 1'b1;
      in_data  = a[i][7:0];
      if (col && i == 0) begin
        w_we   = 1'b1;
        w_addr = 2'd0;
        w_data = col_w[7:0];
      end
      while (!in_ready && stalls < 50) begin
        @(negedge clk);
        stalls++;
      end
      @(negedge clk);
      w_we = 1'b0;
    end
    in_valid = 1'b0;
    if (stalls >= 50) check("send_timeout", 32'(stalls), 32'd0);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic frame_expect(input string name, input int a0, input int a1, input int a2,
                              input int a3, input int exp);
    int st;
    int lat;
    send_frame(a0, a1, a2, a3, 1'b0, 0, st);
    wait_out(lat);
    check({name, "_lat"}, 32'(lat), 32'd2);
    check(name, out_data, 32'(exp));
    take();
  endtask

  initial begin
    int st;
    int lat;
    int v;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);
    reset = 1'b0;

    wr_w(0, 5); wr_w(1, 19); wr_w(2, 20); wr_w(3, -2);
    frame_expect("f_64s", 64, 64, 64, 64, 34);
    frame_expect("f_1000", 1, 0, 0, 0, 0);
    frame_expect("f_zero", 0, 0, 0, 0, 0);

    for (int i = 0; i < NUM_IN; i++) wr_w(i, 31);
    frame_expect("f_sat", 127, 127, 127, 127, 127);
    wr_b(32);
    frame_expect("f_b32", 0, 0, 0, 0, 1);
    wr_b(31);
    frame_expect("f_b31", 0, 0, 0, 0, 0);

    // Back-pressure on the result, then an immediate follow-on frame.
    wr_b(0);
    send_frame(10, 10, 10, 10, 1'b0, 0, st);
    wait_out(lat);
    repeat (5) begin
      check("hold_in_ready", in_ready, 32'd0);
      check("hold_out_data", out_data, 32'd19);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_out_valid", out_valid, 32'd0);
    send_frame(1, 1, 1, 1, 1'b0, 0, st);
    check("next_no_stall", 32'(st), 32'd0);
    wait_out(lat);
    check("f_next", out_data, 32'd2);
    take();

    // Reset in the middle of a frame.
    in_valid = 1'b1; in_data = 8'sd50;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out_valid", out_valid, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    wr_b(32);
    frame_expect("f_wzero", 100, 100, 100, 100, 1);
    wr_w(0, 1); wr_w(1, 2); wr_w(2, 3); wr_w(3, 4);
    frame_expect("f_fresh", 10, 20, 30, 40, 5);

    // Weight write on the same index as the accept: old weight used.
    send_frame(64, 0, 0, 0, 1'b1, 100, st);
    wait_out(lat);
    check("f_collide", out_data, 32'd2);
    take();
    frame_expect("f_after_col", 64, 0, 0, 0, 101);

    // Randomized traffic checked cycle by cycle against the model.
    fork
      begin
        bit rdy_prev = 1'b0;
        repeat (3000) begin
          if (!in_valid || rdy_prev) begin
            in_valid = ($urandom % 4) != 0;
            if ($urandom % 4 == 0) v = int'($urandom);
            else v = int'($urandom_range(0, 50)) - 10;
            in_data = v[7:0];
          end
          rdy_prev = in_ready;
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3000) begin
          out_ready = ($urandom % 3) == 0;
          @(negedge clk);
        end
        out_ready = 1'b0;
      end
      begin
        int wv;
        int bv;
        repeat (3000) begin
          w_we   = ($urandom % 8) == 0;
          w_addr = 2'($urandom);
          wv     = int'($urandom_range(0, 35)) - 5;
          w_data = wv[7:0];
          b_we   = ($urandom % 16) == 0;
          bv     = int'($urandom_range(0, 4000)) - 2000;
          b_data = bv[ACC_W-1:0];
          reset  = ($urandom % 400) == 0;
          @(negedge clk);
        end
        w_we  = 1'b0;
        b_we  = 1'b0;
        reset = 1'b0;
      end
    join

    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
